seq_mult_hs: RTL and testbench
==============================

Name: seq_mult_hs

Overview:
- Parametrised sequential shift-add multiplier; the multi-cycle, handshaked successor of the combinational 4x4 array multiplier.
- Trades area for latency: one partial product per clock.
- Adds a per-transaction signed/unsigned mode and valid/ready flow control on both sides.
- Sits between datapath stages that tolerate WIDTH-cycle latency (DSP filters, address scaling).

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32. The product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair and mode present.
- in_ready  out  1  block can accept a new operation.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2*WIDTH  product.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE.
  - in_ready=0 while rst_n is low, then 1 from the first clock after release (IDLE).
  - out_valid=0, busy=0, p=0, and all internal registers are cleared.
- Reset mid-operation discards the operation; no partial result is ever presented.
- State machine:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge (accept edge T0):
    - capture |a| and |b| (magnitudes when signed_mode=1, raw values otherwise);
    - capture neg = signed_mode & (a[MSB]^b[MSB]);
    - clear the accumulator, load count=WIDTH, go to BUSY.
  - BUSY: each cycle processes one bit.
    - If the multiplier LSB is 1, add the shifted multiplicand to the 2*WIDTH accumulator.
    - Shift the multiplier right and the multiplicand left; decrement count.
    - On the edge where count reaches 0, go to DONE and write p with the accumulator, negated (two's complement, 2*WIDTH bits) if neg=1.
  - DONE: out_valid=1 and p is held stable.
    - On an out_valid&&out_ready edge, go to IDLE; out_valid drops and p keeps its last value.
- Latency: out_valid rises at edge T0+WIDTH.
- Minimum issue interval is WIDTH+2 cycles. There is no accept in DONE, even when out_ready is high.
- Operands and signed_mode are sampled only at the accept edge. Later input changes have no effect.
- in_valid asserted outside IDLE is ignored and not queued. The upstream source holds it per the valid/ready rules.
- Magnitude width rules:
  - |a| and |b| are held in WIDTH-bit unsigned registers.
  - The most-negative input -2^(WIDTH-1) gives magnitude 2^(WIDTH-1), which fits, so no overflow.
  - (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2) is representable in the 2*WIDTH signed product.
- A zero product with neg=1 yields p=0; negating zero gives zero.
- The product is always exact. There is no saturation or truncation.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined: in BUSY, if the shifted multiplier register is zero after the current step, go to DONE on that edge regardless of count.
  - The result is identical to the non-early-exit result.
  - Latency becomes max(1, position of the highest set bit of |b| + 1) cycles after T0.
  - b=0 gives 1 cycle.
- Undefined: fixed WIDTH-cycle latency for every operation.

Test Plan:
- Reset, WIDTH=4: hold rst_n low for 3 cycles with in_valid=1 -> out_valid=0, busy=0, p=0, no accept. After release, in_ready=1 from the first edge.
- Unsigned, WIDTH=4: a=15, b=11, signed_mode=0 -> out_valid at T0+4, p=8'hA5 (165). out_ready held 0 for 5 cycles -> p stable and out_valid stays 1.
- Signed, WIDTH=4:
  - a=4'b1000 (-8), b=4'b1000 (-8) -> p=8'h40 (64).
  - a=-8, b=7 -> p=8'hC8 (-56).
  - a=-3, b=0 -> p=8'h00.
- Mid-operation reset, WIDTH=8: a=200, b=100, unsigned; pulse rst_n low at T0+3 -> out_valid never asserts for that operation. A following 3*5 gives p=15 at T0'+8.
- Back-to-back, WIDTH=8, random: in_valid held high with random signed/unsigned pairs for 500 operations, random out_ready -> every p matches the reference model, in_ready only in IDLE, no lost or duplicated results.
- SEQ_MULT_EARLY_EXIT_EN, WIDTH=8: b=0 -> out_valid at T0+1; b=1 -> T0+1; b=8'h80 unsigned -> T0+8. Products are identical to the build without the macro.

Source files
------------

// File: rtl/seq_mult_hs_if.sv
// Handshake bundle for seq_mult_hs: operand/mode request side and product response side.
interface seq_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier, one partial product per clock, valid/ready on both sides.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult_hs #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mult_hs_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic              up;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     acc_nx;
  logic [PW-1:0]     p_q;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  mplier_nx;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic              accept;
  logic              last;
  logic              in_ready_c;

  // Magnitude fits WIDTH unsigned bits even for the most-negative input.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
    logic signed [WIDTH-1:0] sv;
    sv = signed'(v);
    if (sm && (sv < 0)) return unsigned'(-sv);
    return v;
  endfunction

  function automatic logic [PW-1:0] cond_negate(input logic [PW-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    acc_nx     = acc + (mplier[0] ? mcand : '0);
    mplier_nx  = mplier >> 1;
    case (state)
      IDLE: begin
        in_ready_c = up;
        if (bus.in_valid && up) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
        last = (cnt == CW'(1)) || (mplier_nx == '0);
`else
        last = (cnt == CW'(1));
`endif
        if (last) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.p         = p_q;

  // up holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up     <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      p_q    <= '0;
    end else begin
      up <= 1'b1;
      if (accept) begin
        mcand  <= PW'(magnitude(bus.a, bus.signed_mode));
        mplier <= magnitude(bus.b, bus.signed_mode);
        neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        acc    <= '0;
        cnt    <= CW'(WIDTH);
      end else if (state == BUSY) begin
        acc    <= acc_nx;
        mplier <= mplier_nx;
        mcand  <= mcand << 1;
        cnt    <= cnt - CW'(1);
        if (last) p_q <= cond_negate(acc_nx, neg);
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: WIDTH=4 and WIDTH=8 instances, directed table plus reset and random back-to-back traffic.
module tb_seq_mult_hs;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_mult_hs_if #(.WIDTH(4)) i4();
  seq_mult_hs_if #(.WIDTH(8)) i8();

  seq_mult_hs #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  seq_mult_hs #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          w;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ov(input int s);
    return (s == 4) ? i4.out_valid : i8.out_valid;
  endfunction

  function automatic logic ir(input int s);
    return (s == 4) ? i4.in_ready : i8.in_ready;
  endfunction

  function automatic logic bz(input int s);
    return (s == 4) ? i4.busy : i8.busy;
  endfunction

  function automatic logic [15:0] pv(input int s);
    return (s == 4) ? {8'h00, i4.p} : i8.p;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int x, y;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  // Expected cycles from accept edge to out_valid.
  function automatic int lat_of(input int w, input logic [7:0] b, input logic sm);
    logic [3:0] b4;
    int bv;
    int l;
    b4 = b[3:0];
    if (w == 4) bv = sm ? int'($signed(b4)) : int'(b4);
    else        bv = sm ? int'($signed(b)) : int'(b);
    if (bv < 0) bv = -bv;
`ifdef SEQ_MULT_EARLY_EXIT_EN
    l = 1;
    for (int i = 0; i < w; i++) if (((bv >> i) & 1) != 0) l = i + 1;
`else
    l = w;
`endif
    return l;
  endfunction

  task automatic set_in(input int s, input logic v, input logic [7:0] a, input logic [7:0] b, input logic sm);
    if (s == 4) begin
      i4.in_valid = v; i4.a = a[3:0]; i4.b = b[3:0]; i4.signed_mode = sm;
    end else begin
      i8.in_valid = v; i8.a = a; i8.b = b; i8.signed_mode = sm;
    end
  endtask

  task automatic set_or(input int s, input logic v);
    if (s == 4) i4.out_ready = v;
    else        i8.out_ready = v;
  endtask

  task automatic run_op(input int s, input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic [15:0] ep, input int hold, input string nm);
    int n;
    @(negedge clk);
    set_or(s, 1'b0);
    set_in(s, 1'b1, a, b, sm);
    n = 0;
    while (!ir(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " in_ready"}, 64'(ir(s)), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(s, 1'b0, ~a, ~b, ~sm);
    n = 0;
    while (!ov(s) && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat_of(s, b, sm)));
    chk({nm, " p"}, 64'(pv(s)), 64'(ep));
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk({nm, " held out_valid"}, 64'(ov(s)), 64'd1);
      chk({nm, " held p"}, 64'(pv(s)), 64'(ep));
    end
    set_or(s, 1'b1);
    @(negedge clk);
    set_or(s, 1'b0);
    chk({nm, " out_valid drop"}, 64'(ov(s)), 64'd0);
    chk({nm, " p kept"}, 64'(pv(s)), 64'(ep));
  endtask

  initial begin
    rst_n = 1'b0;
    i4.in_valid = 1'b1; i4.a = 4'd3; i4.b = 4'd3; i4.signed_mode = 1'b0; i4.out_ready = 1'b0;
    i8.in_valid = 1'b0; i8.a = '0;   i8.b = '0;   i8.signed_mode = 1'b0; i8.out_ready = 1'b0;

    vecs[0]  = '{4,  8'h0F, 8'h0B, 1'b0, 16'h00A5, 5};
    vecs[1]  = '{4,  8'h08, 8'h08, 1'b1, 16'h0040, 0};
    vecs[2]  = '{4,  8'h08, 8'h07, 1'b1, 16'h00C8, 0};
    vecs[3]  = '{4,  8'h0D, 8'h00, 1'b1, 16'h0000, 0};
    vecs[4]  = '{4,  8'h0F, 8'h0F, 1'b1, 16'h0001, 0};
    vecs[5]  = '{4,  8'h03, 8'h0B, 1'b1, 16'h00F1, 0};
    vecs[6]  = '{4,  8'h0F, 8'h0F, 1'b0, 16'h00E1, 0};
    vecs[7]  = '{8,  8'hC8, 8'h64, 1'b0, 16'h4E20, 0};
    vecs[8]  = '{8,  8'h80, 8'h80, 1'b1, 16'h4000, 0};
    vecs[9]  = '{8,  8'h80, 8'h80, 1'b0, 16'h4000, 2};
    vecs[10] = '{8,  8'h37, 8'h00, 1'b0, 16'h0000, 0};
    vecs[11] = '{8,  8'h37, 8'h01, 1'b0, 16'h0037, 0};
    vecs[12] = '{8,  8'hFF, 8'h7F, 1'b1, 16'hFF81, 0};
    vecs[13] = '{8,  8'hFF, 8'hFF, 1'b0, 16'hFE01, 0};
    vecs[14] = '{8,  8'h85, 8'h01, 1'b1, 16'hFF85, 0};

    // Reset held with in_valid high: nothing accepted, outputs cleared.
    repeat (3) begin
      @(negedge clk);
      chk("rst out_valid", 64'(i4.out_valid), 64'd0);
      chk("rst busy", 64'(i4.busy), 64'd0);
      chk("rst p", 64'(i4.p), 64'd0);
      chk("rst in_ready", 64'(i4.in_ready), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("release in_ready before edge", 64'(i4.in_ready), 64'd0);
    @(negedge clk);
    chk("release no accept", 64'(i4.busy), 64'd0);
    chk("release in_ready after edge", 64'(i4.in_ready), 64'd1);
    i4.in_valid = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p, vecs[i].hold,
             $sformatf("vec%0d", i));

    // Reset in the middle of 200*100: operation must vanish.
    begin : midreset
      int  n;
      logic seen;
      @(negedge clk);
      set_in(8, 1'b1, 8'd200, 8'd100, 1'b0);
      n = 0;
      while (!i8.in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      @(negedge clk);
      set_in(8, 1'b0, 8'd0, 8'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("midrst busy before", 64'(i8.busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst busy", 64'(i8.busy), 64'd0);
      chk("midrst p", 64'(i8.p), 64'd0);
      rst_n = 1'b1;
      seen = 1'b0;
      i8.out_ready = 1'b1;
      repeat (12) begin
        @(negedge clk);
        seen = seen | i8.out_valid;
      end
      i8.out_ready = 1'b0;
      chk("midrst no result", 64'(seen), 64'd0);
      run_op(8, 8'd3, 8'd5, 1'b0, 16'd15, 0, "post-reset 3*5");
    end

    // Back-to-back random traffic against the reference model.
    begin : rnd
      logic [15:0] q[$];
      logic [15:0] exp_p;
      logic [7:0]  ra, rb;
      logic        rs;
      int issued, got, cyc;
      issued = 0; got = 0; cyc = 0;
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      while (got < 500 && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        i8.in_valid    = (issued < 500);
        i8.a           = ra;
        i8.b           = rb;
        i8.signed_mode = rs;
        i8.out_ready   = 1'($urandom_range(0, 1));
        if (i8.in_valid && i8.in_ready) begin
          chk("rnd accept only idle", 64'(i8.busy), 64'd0);
          q.push_back(ref8(ra, rb, rs));
          issued++;
          ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
        end
        if (i8.out_valid && i8.out_ready) begin
          chk("rnd result expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            exp_p = q.pop_front();
            chk($sformatf("rnd p #%0d", got), 64'(i8.p), 64'(exp_p));
          end
          got++;
        end
      end
      i8.in_valid  = 1'b0;
      i8.out_ready = 1'b0;
      chk("rnd results received", 64'(got), 64'd500);
      chk("rnd outstanding", 64'(q.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
